fetch_redirect: RTL and testbench
=================================

# fetch_redirect

Fetch-side owner of the program counter for the LC-3b pipeline. It consumes resolved control transfers (taken BR, JMP/RET, JSR/JSRR, TRAP) from the MEM stage and redirects the fetch PC to the target. It marks the fetch in flight as wrong-path and ignores further redirect requests during the shadow window in which the downstream flush controller squashes younger instructions. It is the producer-side counterpart of that flush controller: this block issues the redirect, the flush controller cleans up behind it.

## Interface
- FLUSH_DEPTH, 3, number of non-stalled cycles after an applied redirect during which redirect requests are ignored; must be ≥1 and must match the squash depth downstream.
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; one clock; reset is sampled on posedge clk.
- stall  in  1  global pipeline stall (cache miss / memory wait); freezes all block state.
- redirect_valid  in  1  MEM-stage control transfer resolved taken this cycle.
- redirect_target  in  16  target address accompanying redirect_valid.
- pc  out  16  current fetch address (registered).
- fetch_valid  out  1  the instruction fetched at pc this cycle is on the correct path.
- flush_req  out  1  single-cycle pulse: redirect applied this cycle.
- shadow_active  out  1  block is inside the post-redirect shadow window.
- redirect_count  out  16  number of applied redirects, saturating.

## Operation
- States: RUN, PEND, SHADOW. A shadow counter of width clog2(FLUSH_DEPTH+1), a 16-bit pending target register, pc, and redirect_count are all registered.
- RUN, stall=0, redirect_valid=0: pc <= pc+2 (mod 2^16, wraps 0xFFFE→0x0000). fetch_valid=1, flush_req=0.
- RUN, stall=0, redirect_valid=1 (applied redirect):
  - pc <= {redirect_target[15:1],1'b0}.
  - flush_req=1 and fetch_valid=0 this cycle.
  - shadow counter <= FLUSH_DEPTH; state <= SHADOW.
  - redirect_count increments, saturating at 0xFFFF.
- RUN, stall=1, redirect_valid=1: latch redirect_target into the pending register; state <= PEND; pc holds; fetch_valid=0; flush_req=0.
- RUN, stall=1, redirect_valid=0: all state holds; fetch_valid=1.
- PEND, stall=1: hold. fetch_valid=0. redirect_valid/redirect_target are ignored, so the first latched target wins.
- PEND, stall=0: apply the pending target exactly as an applied redirect (pc load, flush_req=1, fetch_valid=0, count++, enter SHADOW). Live redirect_valid is ignored that cycle.
- SHADOW:
  - redirect_valid is ignored and not counted; shadow_active=1; fetch_valid=1.
  - stall=0: pc <= pc+2 and the counter decrements. When the counter reaches 0, state <= RUN.
  - stall=1: everything holds.
- shadow_active=1 only in SHADOW. flush_req is asserted only on the apply cycle.

## Timing
- Reset values: pc=0x0000, state RUN, shadow counter 0, pending target 0x0000, redirect_count 0, fetch_valid=1, flush_req=0, shadow_active=0.
- Reset has priority over every input, including mid-PEND and mid-SHADOW. The pending redirect is discarded.
- Redirect latency: a redirect applied at edge N makes pc=target from cycle N+1.
- fetch_valid and flush_req are combinational from state, stall and redirect_valid. pc, shadow_active and redirect_count are registered outputs.
- Shadow length: exactly FLUSH_DEPTH non-stalled cycles after the apply cycle. Stalled cycles do not count. redirect_valid in the first non-stalled RUN cycle after the shadow ends is honored.
- Target bit 0 is always cleared. No alignment fault is raised.

## Test plan
- Reset then 4 free-running cycles, stall=0 → pc 0x0000, 0x0002, 0x0004, 0x0006; fetch_valid=1 throughout; redirect_count=0.
- At pc=0x0010, redirect_valid=1, target=0x3001 → flush_req=1 and fetch_valid=0 that cycle; next pc=0x3000; shadow_active=1 for 3 cycles (pc 0x3000/0x3002/0x3004); redirect_count=1.
- Redirect with stall=1 for 5 cycles, target=0x0200; during the stall the live target changes to 0x0400 → state PEND, fetch_valid=0, pc frozen; on the first stall=0 cycle flush_req=1, then pc=0x0200.
- Redirect to 0x1000, then redirect_valid=1 (target 0x5555) on each of the 3 shadow cycles, with stall=1 inserted mid-shadow for 2 cycles → all ignored; shadow lasts 3 non-stalled cycles; a redirect to 0x2000 on the next cycle is applied; redirect_count=2.
- pc=0xFFFE, no redirect → pc wraps to 0x0000. Force redirect_count to 0xFFFF (65535 redirects or preload) then apply a redirect → count stays 0xFFFF.
- reset asserted in PEND and again in SHADOW, together with redirect_valid=1 → next cycle pc=0x0000, RUN, shadow_active=0, flush_req=0, redirect_count=0.

Source files
------------

// File: rtl/fetch_redirect.sv
// Fetch PC owner for the LC-3b pipeline: applies resolved MEM-stage control
// transfers, then ignores further redirects while the downstream squash runs.
//
// state  | meaning
// -------+------------------------------------------------------------------
// RUN    | sequential fetch; a redirect is applied now, or parked if stalled
// PEND   | redirect seen during a stall; applied on the first unstalled cycle
// SHADOW | post-redirect squash window; redirects ignored for FLUSH_DEPTH cycles
module fetch_redirect #(
    parameter int FLUSH_DEPTH = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [15:0] redirect_target_i,
    output logic [15:0] pc_o,
    output logic        fetch_valid_o,
    output logic        flush_req_o,
    output logic        shadow_active_o,
    output logic [15:0] redirect_count_o
);

    localparam int CNT_W = $clog2(FLUSH_DEPTH + 1);
    localparam logic [CNT_W-1:0] SHADOW_LOAD = CNT_W'(FLUSH_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_PEND   = 2'd1;
    localparam logic [1:0] ST_SHADOW = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] shadow_cnt_q, shadow_cnt_d;
    logic [15:0]      pend_tgt_q, pend_tgt_d;
    logic [15:0]      pc_q, pc_d;
    logic [15:0]      redirect_count_q, redirect_count_d;

    logic             apply;
    logic [15:0]      apply_tgt;
    logic [15:0]      pc_inc;

    assign pc_inc = pc_q + 16'd2;

    always_comb begin
        state_d          = state_q;
        shadow_cnt_d     = shadow_cnt_q;
        pend_tgt_d       = pend_tgt_q;
        pc_d             = pc_q;
        redirect_count_d = redirect_count_q;
        apply            = 1'b0;
        apply_tgt        = redirect_target_i;
        fetch_valid_o    = 1'b1;
        flush_req_o      = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (!stall_i) begin
                    if (redirect_valid_i) begin
                        apply = 1'b1;
                    end else begin
                        pc_d = pc_inc;
                    end
                end else if (redirect_valid_i) begin
                    pend_tgt_d    = redirect_target_i;
                    state_d       = ST_PEND;
                    fetch_valid_o = 1'b0;
                end
            end
            ST_PEND: begin
                // The parked target wins over anything arriving on the live inputs.
                fetch_valid_o = 1'b0;
                if (!stall_i) begin
                    apply     = 1'b1;
                    apply_tgt = pend_tgt_q;
                end
            end
            ST_SHADOW: begin
                if (!stall_i) begin
                    pc_d         = pc_inc;
                    shadow_cnt_d = shadow_cnt_q - CNT_ONE;
                    if (shadow_cnt_q == CNT_ONE) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (apply) begin
            pc_d          = {apply_tgt[15:1], 1'b0};
            flush_req_o   = 1'b1;
            fetch_valid_o = 1'b0;
            shadow_cnt_d  = SHADOW_LOAD;
            state_d       = ST_SHADOW;
            if (redirect_count_q != 16'hFFFF) begin
                redirect_count_d = redirect_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q          <= ST_RUN;
            shadow_cnt_q     <= '0;
            pend_tgt_q       <= 16'h0000;
            pc_q             <= 16'h0000;
            redirect_count_q <= 16'h0000;
        end else begin
            state_q          <= state_d;
            shadow_cnt_q     <= shadow_cnt_d;
            pend_tgt_q       <= pend_tgt_d;
            pc_q             <= pc_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign pc_o             = pc_q;
    assign shadow_active_o  = (state_q == ST_SHADOW);
    assign redirect_count_o = redirect_count_q;

endmodule

// File: tb/tb_fetch_redirect.sv
// Bench for fetch_redirect: directed scenarios plus random traffic, all checked
// against a cycle-level behavioural model of the redirect rules.
module tb_fetch_redirect;

    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        rv;
    logic [15:0] tgt;
    logic [15:0] pc;
    logic        fetch_valid;
    logic        flush_req;
    logic        shadow_active;
    logic [15:0] redirect_count;

    fetch_redirect #(.FLUSH_DEPTH(DEPTH)) dut (
        .clk_i             (clk),
        .reset_i           (rst),
        .stall_i           (stall),
        .redirect_valid_i  (rv),
        .redirect_target_i (tgt),
        .pc_o              (pc),
        .fetch_valid_o     (fetch_valid),
        .flush_req_o       (flush_req),
        .shadow_active_o   (shadow_active),
        .redirect_count_o  (redirect_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending flag + remaining shadow cycles, no state encoding.
    logic [15:0] m_pc;
    logic [15:0] m_count;
    logic        m_pend;
    logic [15:0] m_pend_tgt;
    int          m_shadow;

    logic [15:0] obs_pc, exp_pc, obs_cnt, exp_cnt;
    logic        obs_fv, exp_fv, obs_fr, exp_fr, obs_sa, exp_sa;

    task automatic model_apply(input logic [15:0] t);
        m_pc     = t & 16'hFFFE;
        m_count  = (m_count == 16'hFFFF) ? m_count : m_count + 16'd1;
        m_shadow = DEPTH;
        m_pend   = 1'b0;
    endtask

    // Drive one cycle, capture DUT and model views of that cycle, then clock.
    task automatic step(input logic r, input logic s, input logic v, input logic [15:0] t);
        rst = r; stall = s; rv = v; tgt = t;
        #1;
        exp_pc  = m_pc;
        exp_cnt = m_count;
        exp_sa  = (m_shadow > 0);
        if (m_pend) begin
            exp_fv = 1'b0;
            exp_fr = !s;
        end else if (m_shadow > 0) begin
            exp_fv = 1'b1;
            exp_fr = 1'b0;
        end else begin
            exp_fv = !v;
            exp_fr = v && !s;
        end
        obs_pc = pc; obs_cnt = redirect_count; obs_fv = fetch_valid;
        obs_fr = flush_req; obs_sa = shadow_active;
        @(posedge clk);
        #1;
        if (r) begin
            m_pc = 16'h0000; m_count = 16'h0000; m_pend = 1'b0;
            m_pend_tgt = 16'h0000; m_shadow = 0;
        end else if (m_pend) begin
            if (!s) model_apply(m_pend_tgt);
        end else if (m_shadow > 0) begin
            if (!s) begin
                m_pc = m_pc + 16'd2;
                m_shadow = m_shadow - 1;
            end
        end else if (!s) begin
            if (v) model_apply(t);
            else m_pc = m_pc + 16'd2;
        end else if (v) begin
            m_pend = 1'b1;
            m_pend_tgt = t;
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b1, 16'h1234);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        n_checks++; if (obs_pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", obs_pc, 16'h0000); end
        n_checks++; if (obs_fv !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_valid got=%b exp=1", obs_fv); end
        n_checks++; if (obs_fr !== 1'b0) begin n_fail++; $display("FAIL reset_flush_req got=%b exp=0", obs_fr); end
        n_checks++; if (obs_sa !== 1'b0) begin n_fail++; $display("FAIL reset_shadow got=%b exp=0", obs_sa); end
        n_checks++; if (obs_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_count got=%h exp=0000", obs_cnt); end
    endtask

    task automatic test_free_run();
        for (int i = 1; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0000);
            n_checks++; if (obs_pc !== 16'(2 * i)) begin n_fail++; $display("FAIL free_pc[%0d] got=%h exp=%h", i, obs_pc, 16'(2 * i)); end
            n_checks++; if (obs_fv !== 1'b1 || obs_cnt !== 16'h0000) begin n_fail++; $display("FAIL free_fv_cnt[%0d] got=%b/%h exp=1/0000", i, obs_fv, obs_cnt); end
        end
    endtask

    task automatic test_redirect();
        for (int g = 0; g < 16 && m_pc != 16'h0010; g++) step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 16'h3001);
        n_checks++; if (obs_pc !== 16'h0010) begin n_fail++; $display("FAIL redir_pc got=%h exp=0010", obs_pc); end
        n_checks++; if (obs_fr !== 1'b1 || obs_fv !== 1'b0) begin n_fail++; $display("FAIL redir_fr_fv got=%b/%b exp=1/0", obs_fr, obs_fv); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0000);
            n_checks++; if (obs_pc !== 16'h3000 + 16'(2 * i) || obs_sa !== 1'b1) begin n_fail++; $display("FAIL redir_shadow[%0d] pc/sa got=%h/%b exp=%h/1", i, obs_pc, obs_sa, 16'h3000 + 16'(2 * i)); end
            n_checks++; if (obs_cnt !== 16'h0001 || obs_fv !== 1'b1) begin n_fail++; $display("FAIL redir_cnt_fv[%0d] got=%h/%b exp=0001/1", i, obs_cnt, obs_fv); end
        end
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        n_checks++; if (obs_pc !== 16'h3006 || obs_sa !== 1'b0) begin n_fail++; $display("FAIL redir_exit pc/sa got=%h/%b exp=3006/0", obs_pc, obs_sa); end
    endtask

    task automatic test_stall_pend();
        step(1'b0, 1'b1, 1'b1, 16'h0200);
        n_checks++; if (obs_fv !== 1'b0 || obs_fr !== 1'b0 || obs_pc !== 16'h3008) begin n_fail++; $display("FAIL pend_entry fv/fr/pc got=%b/%b/%h exp=0/0/3008", obs_fv, obs_fr, obs_pc); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1, 16'h0400);
            n_checks++; if (obs_fv !== 1'b0 || obs_fr !== 1'b0 || obs_pc !== 16'h3008) begin n_fail++; $display("FAIL pend_hold[%0d] fv/fr/pc got=%b/%b/%h exp=0/0/3008", i, obs_fv, obs_fr, obs_pc); end
        end
        step(1'b0, 1'b0, 1'b1, 16'h0400);
        n_checks++; if (obs_fr !== 1'b1 || obs_fv !== 1'b0) begin n_fail++; $display("FAIL pend_apply fr/fv got=%b/%b exp=1/0", obs_fr, obs_fv); end
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        n_checks++; if (obs_pc !== 16'h0200 || obs_sa !== 1'b1 || obs_cnt !== 16'h0002) begin n_fail++; $display("FAIL pend_target pc/sa/cnt got=%h/%b/%h exp=0200/1/0002", obs_pc, obs_sa, obs_cnt); end
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_shadow_ignore();
        logic        stl [5];
        logic [15:0] pcs [5];
        stl = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        pcs = '{16'h1000, 16'h1002, 16'h1002, 16'h1002, 16'h1004};
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 16'h1000);
        n_checks++; if (obs_fr !== 1'b1) begin n_fail++; $display("FAIL shadow_apply fr got=%b exp=1", obs_fr); end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, stl[i], 1'b1, 16'h5555);
            n_checks++; if (obs_pc !== pcs[i] || obs_sa !== 1'b1 || obs_fr !== 1'b0 || obs_fv !== 1'b1) begin
                n_fail++; $display("FAIL shadow_ign[%0d] pc/sa/fr/fv got=%h/%b/%b/%b exp=%h/1/0/1", i, obs_pc, obs_sa, obs_fr, obs_fv, pcs[i]);
            end
        end
        step(1'b0, 1'b0, 1'b1, 16'h2000);
        n_checks++; if (obs_pc !== 16'h1006 || obs_sa !== 1'b0 || obs_fr !== 1'b1) begin n_fail++; $display("FAIL shadow_after pc/sa/fr got=%h/%b/%b exp=1006/0/1", obs_pc, obs_sa, obs_fr); end
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        n_checks++; if (obs_pc !== 16'h2000 || obs_cnt !== 16'h0002) begin n_fail++; $display("FAIL shadow_next pc/cnt got=%h/%h exp=2000/0002", obs_pc, obs_cnt); end
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b0, 1'b1, 16'hFFFF);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        n_checks++; if (obs_pc !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_bit0 pc got=%h exp=fffe", obs_pc); end
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        n_checks++; if (obs_pc !== 16'h0000 || obs_sa !== 1'b1) begin n_fail++; $display("FAIL wrap_shadow pc/sa got=%h/%b exp=0000/1", obs_pc, obs_sa); end
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 16'hFFF9);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        n_checks++; if (obs_pc !== 16'hFFFE || obs_sa !== 1'b0) begin n_fail++; $display("FAIL wrap_run_pre pc/sa got=%h/%b exp=fffe/0", obs_pc, obs_sa); end
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        n_checks++; if (obs_pc !== 16'h0000 || obs_fv !== 1'b1) begin n_fail++; $display("FAIL wrap_run pc/fv got=%h/%b exp=0000/1", obs_pc, obs_fv); end
    endtask

    task automatic test_saturate();
        force dut.redirect_count_q = 16'hFFFE;
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        release dut.redirect_count_q;
        m_count = 16'hFFFE;
        step(1'b0, 1'b0, 1'b1, 16'h0ABC);
        n_checks++; if (obs_cnt !== 16'hFFFE || obs_fr !== 1'b1) begin n_fail++; $display("FAIL sat_preload cnt/fr got=%h/%b exp=fffe/1", obs_cnt, obs_fr); end
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        n_checks++; if (obs_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach cnt got=%h exp=ffff", obs_cnt); end
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 16'h0DEF);
        n_checks++; if (obs_fr !== 1'b1) begin n_fail++; $display("FAIL sat_apply fr got=%b exp=1", obs_fr); end
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        n_checks++; if (obs_cnt !== 16'hFFFF || obs_pc !== 16'h0DEE) begin n_fail++; $display("FAIL sat_hold cnt/pc got=%h/%h exp=ffff/0dee", obs_cnt, obs_pc); end
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, 1'b1, 16'h0700);
        step(1'b1, 1'b1, 1'b1, 16'h0900);
        n_checks++; if (obs_fv !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_pend fv got=%b exp=0", obs_fv); end
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        n_checks++; if (obs_pc !== 16'h0000 || obs_sa !== 1'b0 || obs_cnt !== 16'h0000 || obs_fr !== 1'b0 || obs_fv !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pend pc/sa/cnt/fr/fv got=%h/%b/%h/%b/%b exp=0000/0/0000/0/1", obs_pc, obs_sa, obs_cnt, obs_fr, obs_fv);
        end
        step(1'b0, 1'b0, 1'b1, 16'h0800);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        n_checks++; if (obs_pc !== 16'h0800 || obs_sa !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_shadow pc/sa got=%h/%b exp=0800/1", obs_pc, obs_sa); end
        step(1'b1, 1'b0, 1'b1, 16'h0900);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        n_checks++; if (obs_pc !== 16'h0000 || obs_sa !== 1'b0 || obs_cnt !== 16'h0000 || obs_fr !== 1'b0 || obs_fv !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_shadow pc/sa/cnt/fr/fv got=%h/%b/%h/%b/%b exp=0000/0/0000/0/1", obs_pc, obs_sa, obs_cnt, obs_fr, obs_fv);
        end
    endtask

    task automatic test_random();
        logic r, s, v;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 49) == 0);
            s = ($urandom_range(0, 3) == 0);
            v = ($urandom_range(0, 9) < 3);
            step(r, s, v, 16'($urandom));
            n_checks++;
            if ({obs_pc, obs_cnt, obs_fv, obs_fr, obs_sa} !== {exp_pc, exp_cnt, exp_fv, exp_fr, exp_sa}) begin
                n_fail++;
                $display("FAIL random[%0d] pc/cnt/fv/fr/sa got=%h/%h/%b/%b/%b exp=%h/%h/%b/%b/%b",
                         i, obs_pc, obs_cnt, obs_fv, obs_fr, obs_sa, exp_pc, exp_cnt, exp_fv, exp_fr, exp_sa);
            end
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; rv = 1'b0; tgt = 16'h0000;
        m_pc = 16'h0000; m_count = 16'h0000; m_pend = 1'b0;
        m_pend_tgt = 16'h0000; m_shadow = 0;
        test_reset();
        test_free_run();
        test_redirect();
        test_stall_pend();
        test_shadow_ignore();
        test_wrap();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
